// File: rtl/mnist_pkg.sv
// Shared types for the logit normalizer: logit type, default class count
// and the per-bank fill state.
package mnist_pkg;

  typedef logic signed [15:0] feature_type;

  localparam int DEF_NUM_CLASSES = 10;

  typedef enum logic {
    BANK_EMPTY,
    BANK_FULL
  } bank_state_type;

endpackage

// File: rtl/feature_if.sv
// Single-lane valid/ready logit stream.
// The sink takes data in; the source drives data out.
interface feature_if
  import mnist_pkg::*;
#(
  parameter int FW = $bits(feature_type)
);

  logic                 valid;
  logic                 ready;
  logic signed [FW-1:0] features [1];

  modport sink (
    input  valid,
    input  features,
    output ready
  );

  modport source (
    output valid,
    output features,
    input  ready
  );

endinterface

// File: rtl/logit_bank.sv
// One frame bank: logit storage, EMPTY/FULL state and running max.
// Max index tracking is built only with SOFTMAX_ARGMAX_EN.
module logit_bank
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int FW          = $bits(feature_type)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_CLASSES)-1:0] wr_idx,
  input  logic signed [FW-1:0]           wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(NUM_CLASSES)-1:0] rd_idx,
  output bank_state_type                 state,
  output logic signed [FW-1:0]           rd_data,
  output logic signed [FW-1:0]           max_val
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [$clog2(NUM_CLASSES)-1:0] max_idx
`endif
);

  localparam int IW = $clog2(NUM_CLASSES);
  localparam logic [IW-1:0] LAST = IW'(NUM_CLASSES - 1);

  logic signed [FW-1:0] mem [NUM_CLASSES];
  logic                 take_max;

  // Strictly greater keeps the earliest index on ties.
  assign take_max = wr_en &&
                    ((wr_idx == '0) || (wr_data > max_val));

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BANK_EMPTY;
    end else if (wr_en && (wr_idx == LAST)) begin
      state <= BANK_FULL;
    end else if (rd_en && (rd_idx == LAST)) begin
      state <= BANK_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      max_val <= '0;
    end else if (take_max) begin
      max_val <= wr_data;
    end
  end

`ifdef SOFTMAX_ARGMAX_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      max_idx <= '0;
    end else if (take_max) begin
      max_idx <= wr_idx;
    end
  end
`endif

endmodule

// File: rtl/logit_normalizer.sv
// Ping-pong frame buffer emitting each logit minus its frame max.
// Optional argmax outputs with SOFTMAX_ARGMAX_EN.
module logit_normalizer
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int FW          = $bits(feature_type)
) (
  input  logic                           clock,
  input  logic                           reset,
  feature_if.sink                        features_in,
  feature_if.source                      features_out
`ifdef SOFTMAX_ARGMAX_EN
  ,
  output logic [$clog2(NUM_CLASSES)-1:0] class_idx,
  output logic                           class_valid
`endif
);

  localparam int IW = $clog2(NUM_CLASSES);
  localparam logic [IW-1:0] LAST = IW'(NUM_CLASSES - 1);
  localparam logic signed [FW-1:0] MINV = {1'b1, {(FW-1){1'b0}}};

  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [IW-1:0]        in_index;
  logic [IW-1:0]        out_index;
  logic                 in_fire;
  logic                 out_fire;
  logic                 out_valid;
  bank_state_type       st  [2];
  logic signed [FW-1:0] rdd [2];
  logic signed [FW-1:0] mxv [2];
  logic signed [FW:0]   diff;
  logic signed [FW-1:0] norm;
`ifdef SOFTMAX_ARGMAX_EN
  logic [IW-1:0]        mxi [2];
`endif

  assign features_in.ready = (st[wr_ptr] == BANK_EMPTY);
  assign out_valid         = (st[rd_ptr] == BANK_FULL);
  assign features_out.valid = out_valid;

  assign in_fire  = features_in.valid && features_in.ready;
  assign out_fire = out_valid && features_out.ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logit_bank #(
      .NUM_CLASSES (NUM_CLASSES),
      .FW          (FW)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (in_fire && (wr_ptr == 1'(b))),
      .wr_idx  (in_index),
      .wr_data (features_in.features[0]),
      .rd_en   (out_fire && (rd_ptr == 1'(b))),
      .rd_idx  (out_index),
      .state   (st[b]),
      .rd_data (rdd[b]),
      .max_val (mxv[b])
`ifdef SOFTMAX_ARGMAX_EN
      ,
      .max_idx (mxi[b])
`endif
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_index <= '0;
      wr_ptr   <= 1'b0;
    end else if (in_fire) begin
      if (in_index == LAST) begin
        in_index <= '0;
        wr_ptr   <= ~wr_ptr;
      end else begin
        in_index <= in_index + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_index <= '0;
      rd_ptr    <= 1'b0;
    end else if (out_fire) begin
      if (out_index == LAST) begin
        out_index <= '0;
        rd_ptr    <= ~rd_ptr;
      end else begin
        out_index <= out_index + 1'b1;
      end
    end
  end

  // Value never exceeds the max, so only the negative side can overflow.
  assign diff = {rdd[rd_ptr][FW-1], rdd[rd_ptr]} -
                {mxv[rd_ptr][FW-1], mxv[rd_ptr]};
  assign norm = (diff[FW] != diff[FW-1]) ? MINV : diff[FW-1:0];

  assign features_out.features[0] = out_valid ? norm : '0;

`ifdef SOFTMAX_ARGMAX_EN
  assign class_idx   = mxi[rd_ptr];
  assign class_valid = out_valid;
`endif

endmodule

// File: tb/tb_logit_normalizer.sv
// Directed bench for logit_normalizer: table of frames plus stall,
// back-to-back and mid-frame reset sequences.
module tb_logit_normalizer;
  import mnist_pkg::*;

  typedef struct {
    int logit [10];
    int expv  [10];
    int idx;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  feature_if #(.FW(16)) fin ();
  feature_if #(.FW(16)) fout ();

`ifdef SOFTMAX_ARGMAX_EN
  logic [3:0] class_idx;
  logic       class_valid;
`endif

  logit_normalizer #(
    .NUM_CLASSES (10),
    .FW          (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .features_in  (fin.sink),
    .features_out (fout.source)
`ifdef SOFTMAX_ARGMAX_EN
    ,
    .class_idx    (class_idx),
    .class_valid  (class_valid)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  vec_t tbl [6];
  int   in_q [$];
  int   exp_q [$];
  int   expi_q [$];
  int   in_cyc [$];
  int   out_cyc [$];
  int   checks = 0;
  int   failures = 0;
  int   blocked = 0;
  int   out_cnt = 0;
  int   stall_at = -1;
  int   stall_left = 0;
  bit   hold_out = 1'b0;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic push_frame(int v);
    for (int i = 0; i < 10; i++) begin
      in_q.push_back(tbl[v].logit[i]);
      exp_q.push_back(tbl[v].expv[i]);
      expi_q.push_back(tbl[v].idx);
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, book the
  // transfers of the coming posedge, then advance one cycle.
  task automatic step();
    if (fout.valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        chk("out_data", int'(fout.features[0]), exp_q[0]);
`ifdef SOFTMAX_ARGMAX_EN
        chk("class_idx", int'(class_idx), expi_q[0]);
        chk("class_valid", int'(class_valid), 1);
`endif
      end
    end else begin
      chk("idle_zero", int'(fout.features[0]), 0);
    end
    if (hold_out) begin
      fout.ready = 1'b0;
    end else if (stall_left > 0 && out_cnt == stall_at) begin
      fout.ready = 1'b0;
      stall_left--;
    end else begin
      fout.ready = 1'b1;
    end
    fin.valid = (in_q.size() > 0);
    fin.features[0] = (in_q.size() > 0) ? feature_type'(in_q[0]) : '0;
    if (fin.valid && fin.ready) begin
      void'(in_q.pop_front());
      in_cyc.push_back(cyc);
    end
    if (fin.valid && !fin.ready) blocked++;
    if (fout.valid && fout.ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(expi_q.pop_front());
      out_cyc.push_back(cyc);
      out_cnt++;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", in_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    tbl[0].logit = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    tbl[0].expv  = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, 0};
    tbl[0].idx   = 9;
    tbl[1].logit = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    tbl[1].expv  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].idx   = 0;
    tbl[2].logit = '{-32768, 32767, 32767, 32767, 32767,
                     32767, 32767, 32767, 32767, 32767};
    tbl[2].expv  = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].idx   = 1;
    tbl[3].logit = '{3, -2, 7, 7, 0, -100, 7, 1, -32768, 5};
    tbl[3].expv  = '{-4, -9, 0, 0, -7, -107, 0, -6, -32768, -2};
    tbl[3].idx   = 2;
    tbl[4].logit = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    tbl[4].expv  = '{0, -1, -2, -3, -4, -5, -6, -7, -8, -9};
    tbl[4].idx   = 0;
    tbl[5].logit = '{-20000, 20000, 0, 0, 0, 0, 0, 0, 0, -12768};
    tbl[5].expv  = '{-32768, 0, -20000, -20000, -20000, -20000,
                     -20000, -20000, -20000, -32768};
    tbl[5].idx   = 1;

    fin.valid = 1'b0;
    fin.features[0] = '0;
    fout.ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_in_ready", int'(fin.ready), 1);
    chk("rst_out_valid", int'(fout.valid), 0);
    chk("rst_out_data", int'(fout.features[0]), 0);

    // single frames, latency one cycle
    for (int v = 0; v < 6; v++) begin
      in_cyc.delete();
      out_cyc.delete();
      push_frame(v);
      drain(60);
      chk("frame_in_count", in_cyc.size(), 10);
      chk("frame_out_count", out_cyc.size(), 10);
      if (in_cyc.size() == 10 && out_cyc.size() > 0)
        chk("latency", out_cyc[0] - in_cyc[9], 1);
    end

    // two frames back to back, no bubbles
    in_cyc.delete();
    out_cyc.delete();
    push_frame(0);
    push_frame(3);
    drain(80);
    chk("b2b_in_count", in_cyc.size(), 20);
    chk("b2b_out_count", out_cyc.size(), 20);
    if (in_cyc.size() == 20 && out_cyc.size() == 20) begin
      chk("b2b_in_span", in_cyc[19] - in_cyc[0], 19);
      chk("b2b_out_span", out_cyc[19] - out_cyc[0], 19);
      chk("b2b_latency", out_cyc[0] - in_cyc[9], 1);
    end

    // output stall at index 4 with a third frame queued
    blocked = 0;
    out_cnt = 0;
    stall_at = 4;
    stall_left = 3;
    push_frame(0);
    push_frame(4);
    push_frame(5);
    drain(120);
    chk("stall_blocked", blocked, 3);
    chk("stall_used", stall_left, 0);
    stall_at = -1;

    // buffered frame plus partial frame discarded by reset
    hold_out = 1'b1;
    push_frame(1);
    for (int i = 0; i < 4; i++) in_q.push_back(tbl[3].logit[i]);
    for (int n = 0; n < 40 && in_q.size() > 0; n++) step();
    chk("pre_rst_left", in_q.size(), 0);
    chk("pre_rst_valid", int'(fout.valid), 1);
    exp_q.delete();
    expi_q.delete();
    fin.valid = 1'b0;
    fout.ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    hold_out = 1'b0;
    chk("mid_rst_valid", int'(fout.valid), 0);
    chk("mid_rst_ready", int'(fin.ready), 1);
    chk("mid_rst_data", int'(fout.features[0]), 0);
    in_cyc.delete();
    out_cyc.delete();
    push_frame(0);
    drain(60);
    chk("post_rst_out_count", out_cyc.size(), 10);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logit_normalizer.md
LOGIT_NORMALIZER -- requirements
Module: logit_normalizer

Interface
REQ-001 Parameter NUM_CLASSES, default 10, sets the number of logits per frame; legal range is 2..64.
REQ-002 Parameter FW, default $bits(feature_type), sets the signed logit width.
REQ-003 Port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port features_in, feature_if sink, carrying valid (in), ready (out) and features[0] (in, FW bits): the logit stream.
REQ-006 Port features_out, feature_if source, carrying valid (out), ready (in) and features[0] (out, FW bits): the normalized stream.
REQ-007 Port class_idx, output, $clog2(NUM_CLASSES) bits: argmax of the frame being sent (present only with SOFTMAX_ARGMAX_EN).
REQ-008 Port class_valid, output, 1 bit: argmax qualifier (present only with SOFTMAX_ARGMAX_EN).

Function
REQ-009 The block SHALL contain two frame banks, each NUM_CLASSES deep, in ping-pong operation; each bank is either EMPTY or FULL.
REQ-010 A transfer SHALL occur on any cycle where valid and ready are both 1.
REQ-011 features_in.ready SHALL be 1 exactly when the current write bank is EMPTY.
REQ-012 Each input transfer SHALL store the logit at index in_index, then increment in_index.
REQ-013 Each input transfer SHALL update the bank's running max and max index; on a tie the existing index is kept, so the first occurrence wins.
REQ-014 On the transfer at in_index == NUM_CLASSES-1, the bank SHALL become FULL on the next cycle, in_index SHALL wrap to 0, and the write pointer SHALL toggle.
REQ-015 features_out.valid SHALL be 1 exactly when the current read bank is FULL.
REQ-016 features_out.features[0] SHALL equal bank[out_index] minus bank max, computed in FW+1 bits and saturated to -2^(FW-1).
REQ-017 features_out.features[0] SHALL be 0 when features_out.valid is 0.
REQ-018 While valid=1 and ready=0, the output data SHALL hold stable.
REQ-019 On the output transfer at out_index == NUM_CLASSES-1, the bank SHALL become EMPTY on the next cycle, out_index SHALL wrap to 0, and the read pointer SHALL toggle.
REQ-020 Latency SHALL be 1 cycle: the first output is valid in the cycle after the last input of the frame is accepted.
REQ-021 With both ready signals held at 1, consecutive frames SHALL stream with zero bubbles.
REQ-022 A bank freed by TX and a bank being filled by RX in the same cycle SHALL both update correctly.
REQ-023 When both banks are FULL, features_in.ready SHALL be 0 until a bank drains.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL set both banks EMPTY, in_index, out_index and both pointers to 0, features_out.valid=0, features_in.ready=1 (from the next cycle), and class_valid=0.
REQ-025 A reset mid-frame SHALL discard partial and buffered frames without emitting them.

Configuration
REQ-026 With SOFTMAX_ARGMAX_EN defined, class_idx SHALL equal the stored max index of the read bank.
REQ-027 With SOFTMAX_ARGMAX_EN defined, class_valid SHALL equal features_out.valid.
REQ-028 Without SOFTMAX_ARGMAX_EN, the class_idx and class_valid ports and the index tracking SHALL be absent, and the normalized stream SHALL be unchanged.

Structure
REQ-029 mnist_pkg SHALL hold feature_type, the NUM_CLASSES default constant and the bank_state_type enum {BANK_EMPTY, BANK_FULL}.
REQ-030 Sub-module logit_bank SHALL hold one bank's storage, state, running max and max index, and SHALL be instantiated twice.

Verification
REQ-031 Logits 0..9, both ready signals at 1 -> outputs -9..0; class_idx=9 on every output cycle; first output 1 cycle after the last input.
REQ-032 All ten logits = 5 -> ten outputs of 0; class_idx=0 (tie rule).
REQ-033 FW=16, logit0=-32768 and the others 32767 -> first output -32768 (saturated); the other outputs 0; class_idx=1.
REQ-034 Two frames back-to-back -> 20 inputs accepted in 20 consecutive cycles; 20 outputs in 20 consecutive cycles; no gap between frames.
REQ-035 features_out.ready=0 for 3 cycles at out_index 4 -> data held stable; a third frame sees features_in.ready=0 while both banks are FULL; no data lost.
REQ-036 reset=1 after 4 inputs -> next cycle features_out.valid=0 and features_in.ready=1; the following full frame normalizes correctly.
